// File: rtl/edge_noise_filter.sv
`default_nettype none
// ============================================================================
// edge_noise_filter : drops edge-map pixels with too few set neighbours; EDGE_FILTER_DIAGONALS_EN adds diagonal taps. Rev 1.0
// ============================================================================
module edge_noise_filter #(
  parameter int IMG_WIDTH  = 320,
  parameter int SRC_FIRST  = 2240,
  parameter int SRC_LAST   = 74559,
  parameter int DST_OFFSET = 76800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pause,
  input  logic        enable_edge_filter,
  input  logic [3:0]  min_neighbors,
  input  logic [31:0] data_read,
  output logic        wren,
  output logic [17:0] address,
  output logic [31:0] data_write,
  output logic        edge_filter_done
);

`ifdef EDGE_FILTER_DIAGONALS_EN
  localparam int c_num_taps = 9;
`else
  localparam int c_num_taps = 5;
`endif

  localparam logic [17:0] c_width          = 18'(IMG_WIDTH);
  localparam logic [17:0] c_src_first      = 18'(SRC_FIRST);
  localparam logic [17:0] c_src_last       = 18'(SRC_LAST);
  localparam logic [17:0] c_dst_offset     = 18'(DST_OFFSET);
  localparam logic [17:0] c_first_col      = 18'(SRC_FIRST % IMG_WIDTH);
  localparam logic [17:0] c_inner_start    = 18'((SRC_FIRST / IMG_WIDTH + 1) * IMG_WIDTH);
  localparam logic [17:0] c_last_row_start = 18'((SRC_LAST / IMG_WIDTH) * IMG_WIDTH);
  localparam logic [3:0]  c_last_tap       = 4'(c_num_taps - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    DECIDE = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] cursor_q, cursor_d;
  logic [17:0] col_q, col_d;
  logic [17:0] address_q, address_d;
  logic [3:0]  tap_q, tap_d;
  logic [3:0]  count_q, count_d;
  logic        center_q, center_d;
  logic        wren_q, wren_d;
  logic        result_q, result_d;
  logic        done_q, done_d;
  logic        paused_q, paused_d;
  logic [31:0] hold_q, hold_d;

  logic        w_rd_set;
  logic [3:0]  w_final_count;
  logic        w_result;
  logic [17:0] w_next_cursor;
  logic [17:0] w_next_col;
  logic        w_start;
  logic [17:0] w_pix_cursor;
  logic [17:0] w_pix_col;

  // Rows are recognised by address range and columns by a wrapping counter, so no divider is needed.
  function automatic logic is_border(input logic [17:0] cur, input logic [17:0] col);
    return (cur < c_inner_start) || (cur >= c_last_row_start) ||
           (col == 18'd0) || (col == c_width - 18'd1);
  endfunction

  function automatic logic [17:0] tap_addr(input logic [17:0] cur, input logic [3:0] idx);
    logic [17:0] a;
    case (idx)
      4'd1:    a = cur - c_width;
      4'd2:    a = cur + c_width;
      4'd3:    a = cur - 18'd1;
      4'd4:    a = cur + 18'd1;
`ifdef EDGE_FILTER_DIAGONALS_EN
      4'd5:    a = cur - c_width - 18'd1;
      4'd6:    a = cur - c_width + 18'd1;
      4'd7:    a = cur + c_width - 18'd1;
      4'd8:    a = cur + c_width + 18'd1;
`endif
      default: a = cur;
    endcase
    return a;
  endfunction

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    col_d     = col_q;
    address_d = address_q;
    tap_d     = tap_q;
    count_d   = count_q;
    center_d  = center_q;
    wren_d    = wren_q;
    result_d  = result_q;
    done_d    = done_q;
    paused_d  = pause;
    // The RAM keeps following the frozen address during a pause, so the word
    // that was due on the first paused cycle is parked and consumed on resume.
    hold_d    = (pause && !paused_q) ? data_read : hold_q;

    w_rd_set      = (paused_q ? hold_q : data_read) != 32'd0;
    w_final_count = count_q + {3'b000, w_rd_set};
    w_result      = center_q && (w_final_count >= min_neighbors);
    w_next_cursor = cursor_q + 18'd1;
    w_next_col    = (col_q == c_width - 18'd1) ? 18'd0 : col_q + 18'd1;
    w_start       = 1'b0;
    w_pix_cursor  = w_next_cursor;
    w_pix_col     = w_next_col;

    if (!pause) begin
      if (!enable_edge_filter) begin
        state_d   = IDLE;
        wren_d    = 1'b0;
        address_d = 18'd0;
        result_d  = 1'b0;
        done_d    = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            w_start      = 1'b1;
            w_pix_cursor = c_src_first;
            w_pix_col    = c_first_col;
          end
          READ: begin
            // Data arriving now belongs to the tap presented on the previous cycle.
            if (tap_q == 4'd1) begin
              center_d = w_rd_set;
            end else if (tap_q != 4'd0) begin
              count_d = w_final_count;
            end
            if (tap_q == c_last_tap) begin
              state_d = DECIDE;
            end else begin
              tap_d     = tap_q + 4'd1;
              address_d = tap_addr(cursor_q, tap_q + 4'd1);
            end
          end
          DECIDE: begin
            state_d   = WRITE;
            wren_d    = 1'b1;
            address_d = cursor_q + c_dst_offset;
            result_d  = w_result;
          end
          WRITE: begin
            if (cursor_q == c_src_last) begin
              state_d   = DONE;
              wren_d    = 1'b0;
              address_d = 18'd0;
              result_d  = 1'b0;
              done_d    = 1'b1;
            end else begin
              w_start = 1'b1;
            end
          end
          DONE: begin
            wren_d = 1'b0;
            done_d = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    if (w_start) begin
      cursor_d = w_pix_cursor;
      col_d    = w_pix_col;
      result_d = 1'b0;
      done_d   = 1'b0;
      if (is_border(w_pix_cursor, w_pix_col)) begin
        state_d   = WRITE;
        wren_d    = 1'b1;
        address_d = w_pix_cursor + c_dst_offset;
      end else begin
        state_d   = READ;
        wren_d    = 1'b0;
        address_d = w_pix_cursor;
        tap_d     = 4'd0;
        count_d   = 4'd0;
        center_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cursor_q  <= c_src_first;
      col_q     <= c_first_col;
      address_q <= 18'd0;
      tap_q     <= 4'd0;
      count_q   <= 4'd0;
      center_q  <= 1'b0;
      wren_q    <= 1'b0;
      result_q  <= 1'b0;
      done_q    <= 1'b0;
      paused_q  <= 1'b0;
      hold_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      col_q     <= col_d;
      address_q <= address_d;
      tap_q     <= tap_d;
      count_q   <= count_d;
      center_q  <= center_d;
      wren_q    <= wren_d;
      result_q  <= result_d;
      done_q    <= done_d;
      paused_q  <= paused_d;
      hold_q    <= hold_d;
    end
  end

  assign wren             = wren_q;
  assign address          = address_q;
  assign data_write       = {31'd0, result_q};
  assign edge_filter_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_noise_filter.sv
`default_nettype none
// Scoreboard bench for edge_noise_filter on a reduced 12-pixel-wide map (rows 2..9 processed).
module tb_edge_noise_filter;
  localparam int W   = 12;
  localparam int SF  = 24;
  localparam int SL  = 119;
  localparam int DST = 200;
`ifdef EDGE_FILTER_DIAGONALS_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif
  localparam int MAX_NBR = DIAG ? 8 : 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pause;
  logic        enable_edge_filter;
  logic [3:0]  min_neighbors;
  logic [31:0] data_read;
  logic        wren;
  logic [17:0] address;
  logic [31:0] data_write;
  logic        edge_filter_done;

  logic [31:0] mem [0:511];

  typedef struct packed {
    logic [17:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  edge_noise_filter #(
    .IMG_WIDTH (W),
    .SRC_FIRST (SF),
    .SRC_LAST  (SL),
    .DST_OFFSET(DST)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pause             (pause),
    .enable_edge_filter(enable_edge_filter),
    .min_neighbors     (min_neighbors),
    .data_read         (data_read),
    .wren              (wren),
    .address           (address),
    .data_write        (data_write),
    .edge_filter_done  (edge_filter_done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for an address appears on the following cycle.
  always @(posedge clk) data_read <= mem[address[8:0]];

  // Monitor: each distinct write (a held write under pause counts once) pops one expectation.
  logic        prev_wren = 1'b0;
  logic [17:0] prev_addr = '0;
  wr_t         mon_e;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_wren = 1'b0;
    end else begin
      if (wren && !(prev_wren && address == prev_addr)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%0d data=%0d", address, data_write);
        end else begin
          mon_e = exp_q.pop_front();
          if (address !== mon_e.a || data_write !== mon_e.d) begin
            failures++;
            $display("FAIL write got addr=%0d data=%0d expected addr=%0d data=%0d",
                     address, data_write, mon_e.a, mon_e.d);
          end
        end
      end
      prev_wren = wren;
      prev_addr = address;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  function automatic int px(input int r, input int c);
    return (mem[r * W + c] != 32'd0) ? 1 : 0;
  endfunction

  // Reference: every source word in order, border -> 0, else centre AND neighbour count >= threshold.
  task automatic build_expect(input int mn);
    int r, c, n, d;
    exp_q.delete();
    for (int cur = SF; cur <= SL; cur++) begin
      r = cur / W;
      c = cur % W;
      d = 0;
      if (!(r == SF / W || r == SL / W || c == 0 || c == W - 1)) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && (DIAG || dr == 0 || dc == 0))
              n += px(r + dr, c + dc);
        d = (px(r, c) == 1 && n >= mn) ? 1 : 0;
      end
      exp_q.push_back('{a: 18'(cur + DST), d: 32'(d)});
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
  endtask

  task automatic random_map(input int density);
    clear_map();
    for (int i = 0; i <= SL; i++)
      if ($urandom_range(0, 99) < density) mem[i] = 32'd1 << $urandom_range(0, 31);
  endtask

  task automatic wait_write(input int a);
    int cyc = 0;
    while (!(wren && address == 18'(a)) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!(wren && address == 18'(a))) begin
      failures++;
      $display("FAIL wait_write timeout addr=%0d", a);
    end
  endtask

  task automatic run_pass(input int mn, input bit rnd_pause, input int hold_addr);
    int          cyc;
    logic [17:0] ha;
    logic [31:0] hd;
    build_expect(mn);
    min_neighbors      = 4'(mn);
    enable_edge_filter = 1'b1;
    cyc = 0;
    while (!edge_filter_done && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (hold_addr >= 0 && wren && address == 18'(hold_addr)) begin
        pause = 1'b1;
        ha = address;
        hd = data_write;
        repeat (5) begin
          @(negedge clk);
          cyc++;
          check("pause_wren", 32'(wren), 32'd1);
          check("pause_addr", 32'(address), 32'(ha));
          check("pause_data", data_write, hd);
        end
        pause = 1'b0;
        hold_addr = -1;
      end else begin
        pause = rnd_pause ? ($urandom_range(0, 7) == 0) : 1'b0;
      end
    end
    pause = 1'b0;
    check("done_reached", 32'(edge_filter_done), 32'd1);
    check("writes_left", 32'(exp_q.size()), 32'd0);
    repeat (15) @(negedge clk);
    check("done_held", 32'(edge_filter_done), 32'd1);
    check("done_wren", 32'(wren), 32'd0);
    enable_edge_filter = 1'b0;
    @(negedge clk);
    check("idle_done", 32'(edge_filter_done), 32'd0);
    check("idle_addr", 32'(address), 32'd0);
  endtask

  initial begin
    reset_n            = 1'b0;
    pause              = 1'b0;
    enable_edge_filter = 1'b0;
    min_neighbors      = 4'd0;
    clear_map();
    repeat (3) @(negedge clk);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_addr", 32'(address), 32'd0);
    check("rst_data", data_write, 32'd0);
    check("rst_done", 32'(edge_filter_done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_wren0", 32'(wren), 32'd0);

    // Isolated pixel, threshold 1
    mem[5 * W + 5] = 32'h0000_0100;
    run_pass(1, 1'b0, -1);

    // Horizontal run of five, threshold 2
    clear_map();
    for (int c = 4; c <= 8; c++) mem[5 * W + c] = 32'd1 << c;
    run_pass(2, 1'b0, -1);

    // All ones at the maximum threshold, with a held write on an interior pixel
    for (int i = 0; i <= SL; i++) mem[i] = 32'hFFFF_FFFF;
    run_pass(MAX_NBR, 1'b0, SF + W + 1 + DST);

    // Threshold 0 copies the centre; threshold above the tap count clears all
    random_map(50);
    run_pass(0, 1'b1, -1);
    random_map(90);
    run_pass(MAX_NBR + 1, 1'b1, -1);

    for (int k = 0; k < 4; k++) begin
      random_map($urandom_range(20, 90));
      run_pass($urandom_range(0, MAX_NBR + 1), 1'b1, (k == 0) ? (SF + 3 * W + 4 + DST) : -1);
    end

    // Abort by dropping enable mid-pass, then a fresh pass restarts from the first word
    random_map(60);
    build_expect(2);
    min_neighbors      = 4'd2;
    enable_edge_filter = 1'b1;
    wait_write(80 + DST);
    enable_edge_filter = 1'b0;
    @(negedge clk);
    check("abort_wren", 32'(wren), 32'd0);
    check("abort_done", 32'(edge_filter_done), 32'd0);
    check("abort_addr", 32'(address), 32'd0);
    exp_q.delete();
    run_pass(2, 1'b0, -1);

    // Asynchronous reset while pixel 50 is being read
    random_map(60);
    build_expect(3);
    min_neighbors      = 4'd3;
    enable_edge_filter = 1'b1;
    wait_write(49 + DST);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_wren", 32'(wren), 32'd0);
    check("arst_addr", 32'(address), 32'd0);
    check("arst_data", data_write, 32'd0);
    check("arst_done", 32'(edge_filter_done), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    run_pass(3, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
